// File: rtl/sort_mem_arbiter.sv
// Arbitrates the sorter's single memory port between the host and the bubble-sort
// engine, sequences sort jobs, and tracks watchdog, cycle count and access faults.
module sort_mem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16,
    parameter int N       = 10,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              srt_read,
    input  logic              srt_write,
    input  logic [ADDR_W-1:0] srt_addr,
    input  logic [DATA_W-1:0] srt_wdata,
    output logic [DATA_W-1:0] srt_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              job_go,
    output logic              sort_start,
    input  logic              sort_done,
    output logic              busy,
    output logic              job_done,
    output logic              job_err,
    output logic              host_err,
    output logic              srt_viol,
    output logic [CNT_W-1:0]  cycles
);

    typedef enum logic [1:0] {IDLE, START, SORT, FINISH} state_t;

    localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W+1)'(N);
    localparam logic [CNT_W:0]  CNT_LIM  = (CNT_W+1)'(TIMEOUT);

    state_t              state;
    logic                in_range;
    logic                rd_pending;
    logic [DATA_W-1:0]   rdata_hold;
    logic [CNT_W-1:0]    cnt_next;
    logic                timeout_hit;

    assign in_range    = ({1'b0, host_addr} < ADDR_LIM);
    assign host_gnt    = (state == IDLE) && host_req && in_range;
    assign srt_rdata   = mem_data_out;
    assign host_rvalid = rd_pending;
    // Read data is live in the rvalid cycle and held from the capture register afterwards.
    assign host_rdata  = rd_pending ? mem_data_out : rdata_hold;

    assign cnt_next    = (cycles == '1) ? cycles : cycles + 1'b1;
    assign timeout_hit = ({1'b0, cnt_next} >= CNT_LIM);

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        if (state == SORT) begin
            mem_write   = srt_write;
            mem_read    = srt_read && !srt_write;
            mem_addr    = srt_addr;
            mem_data_in = srt_wdata;
        end else if (host_gnt) begin
            mem_write   = host_we;
            mem_read    = !host_we;
            mem_addr    = host_addr;
            mem_data_in = host_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sort_start <= 1'b0;
            busy       <= 1'b0;
            job_done   <= 1'b0;
            job_err    <= 1'b0;
            host_err   <= 1'b0;
            srt_viol   <= 1'b0;
            cycles     <= '0;
            rd_pending <= 1'b0;
            rdata_hold <= '0;
        end else begin
            rd_pending <= host_gnt && !host_we;
            if (rd_pending)
                rdata_hold <= mem_data_out;
            host_err <= (state == IDLE) && host_req && !in_range;
            if (((state != SORT) && (srt_read || srt_write)) || (srt_read && srt_write))
                srt_viol <= 1'b1;
            sort_start <= 1'b0;
            job_done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (job_go) begin
                        state      <= START;
                        sort_start <= 1'b1;
                        busy       <= 1'b1;
                        cycles     <= '0;
                        job_err    <= 1'b0;
                    end
                end
                START: state <= SORT;
                SORT: begin
                    cycles <= cnt_next;
                    // Completion takes priority over the watchdog in the same cycle.
                    if (sort_done) begin
                        state    <= FINISH;
                        busy     <= 1'b0;
                        job_done <= 1'b1;
                    end else if (timeout_hit) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        job_err <= 1'b1;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_mem_arbiter.sv
// Self-checking bench for sort_mem_arbiter: a default instance plus a TIMEOUT=20 instance
// sharing inputs, a behavioural memory, and a queue scoreboard for host reads.
module tb_sort_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [9:0]  host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        srt_read = 1'b0, srt_write = 1'b0;
    logic [9:0]  srt_addr = '0;
    logic [15:0] srt_wdata = '0;
    logic        job_go = 1'b0, sort_done = 1'b0;
    logic [15:0] mem_data_out;

    logic        host_gnt, host_rvalid, mem_read, mem_write, sort_start, busy;
    logic        job_done, job_err, host_err, srt_viol;
    logic [15:0] host_rdata, srt_rdata, mem_data_in, cycles;
    logic [9:0]  mem_addr;

    logic        t_host_gnt, t_host_rvalid, t_mem_read, t_mem_write, t_sort_start, t_busy;
    logic        t_job_done, t_job_err, t_host_err, t_srt_viol;
    logic [15:0] t_host_rdata, t_srt_rdata, t_mem_data_in, t_cycles;
    logic [9:0]  t_mem_addr;

    logic [15:0] mem [0:1023];
    logic [15:0] rd_q = '0;
    logic [15:0] exp_mem [0:1023];
    logic [15:0] exp_q [$];
    logic [15:0] last_rd;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    assign mem_data_out = rd_q;
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_data_in;
        if (mem_read)  rd_q <= mem[mem_addr];
    end

    sort_mem_arbiter dut (
        .clk(clk), .rst(rst), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .srt_read(srt_read), .srt_write(srt_write),
        .srt_addr(srt_addr), .srt_wdata(srt_wdata), .srt_rdata(srt_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .job_go(job_go),
        .sort_start(sort_start), .sort_done(sort_done), .busy(busy), .job_done(job_done),
        .job_err(job_err), .host_err(host_err), .srt_viol(srt_viol), .cycles(cycles)
    );

    sort_mem_arbiter #(.TIMEOUT(20)) dut_to (
        .clk(clk), .rst(rst), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(t_host_gnt), .host_rvalid(t_host_rvalid),
        .host_rdata(t_host_rdata), .srt_read(srt_read), .srt_write(srt_write),
        .srt_addr(srt_addr), .srt_wdata(srt_wdata), .srt_rdata(t_srt_rdata),
        .mem_read(t_mem_read), .mem_write(t_mem_write), .mem_addr(t_mem_addr),
        .mem_data_in(t_mem_data_in), .mem_data_out(mem_data_out), .job_go(job_go),
        .sort_start(t_sort_start), .sort_done(sort_done), .busy(t_busy), .job_done(t_job_done),
        .job_err(t_job_err), .host_err(t_host_err), .srt_viol(t_srt_viol), .cycles(t_cycles)
    );

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b want 0", busy); end
        compared++; if (sort_start !== 1'b0) begin mismatched++; $display("FAIL rst_start: got %b want 0", sort_start); end
        compared++; if (job_done !== 1'b0 || job_err !== 1'b0) begin mismatched++; $display("FAIL rst_job: got %b%b want 00", job_done, job_err); end
        compared++; if (srt_viol !== 1'b0 || host_err !== 1'b0) begin mismatched++; $display("FAIL rst_flags: got %b%b want 00", srt_viol, host_err); end
        compared++; if (cycles !== 16'd0) begin mismatched++; $display("FAIL rst_cycles: got %0d want 0", cycles); end
        compared++; if (host_rvalid !== 1'b0 || host_rdata !== 16'd0) begin mismatched++; $display("FAIL rst_rd: got %b/%h want 0/0000", host_rvalid, host_rdata); end
        compared++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin mismatched++; $display("FAIL rst_mem: got %b%b want 00", mem_read, mem_write); end
    endtask

    task automatic test_srt_viol();
        @(negedge clk); srt_write = 1'b1; srt_addr = 10'd1; srt_wdata = 16'd7; #1;
        compared++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin mismatched++; $display("FAIL viol_block: got %b%b want 00", mem_write, mem_read); end
        @(negedge clk); srt_write = 1'b0;
        compared++; if (srt_viol !== 1'b1) begin mismatched++; $display("FAIL viol_set: got %b want 1", srt_viol); end
        repeat (3) @(negedge clk);
        compared++; if (srt_viol !== 1'b1) begin mismatched++; $display("FAIL viol_sticky: got %b want 1", srt_viol); end
        do_reset();
        compared++; if (srt_viol !== 1'b0) begin mismatched++; $display("FAIL viol_clear: got %b want 0", srt_viol); end
    endtask

    task automatic test_host_write();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); host_req = 1'b1; host_we = 1'b1; host_addr = 10'(i); host_wdata = 16'(9 - i); #1;
            exp_mem[i] = 16'(9 - i);
            compared++; if (host_gnt !== 1'b1 || mem_write !== 1'b1 || mem_read !== 1'b0)
                begin mismatched++; $display("FAIL wr_strobe[%0d]: got gnt=%b w=%b r=%b want 1 1 0", i, host_gnt, mem_write, mem_read); end
            compared++; if (mem_addr !== 10'(i) || mem_data_in !== 16'(9 - i))
                begin mismatched++; $display("FAIL wr_bus[%0d]: got %0d/%h want %0d/%h", i, mem_addr, mem_data_in, i, 16'(9 - i)); end
        end
        @(negedge clk); host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic test_host_read(input int a);
        @(negedge clk); host_req = 1'b1; host_we = 1'b0; host_addr = 10'(a); #1;
        compared++; if (host_gnt !== 1'b1 || mem_read !== 1'b1 || mem_addr !== 10'(a))
            begin mismatched++; $display("FAIL rd_req[%0d]: got gnt=%b r=%b addr=%0d want 1 1 %0d", a, host_gnt, mem_read, mem_addr, a); end
        exp_q.push_back(exp_mem[a]);
        @(negedge clk); host_req = 1'b0; #1;
        compared++;
        if (host_rvalid !== 1'b1 || exp_q.size() == 0) begin
            mismatched++; $display("FAIL rd_valid[%0d]: got %b want 1", a, host_rvalid);
        end else begin
            last_rd = exp_q.pop_front();
            if (host_rdata !== last_rd) begin mismatched++; $display("FAIL rd_data[%0d]: got %h want %h", a, host_rdata, last_rd); end
        end
        @(negedge clk);
        compared++; if (host_rvalid !== 1'b0 || host_rdata !== exp_mem[a])
            begin mismatched++; $display("FAIL rd_hold[%0d]: got %b/%h want 0/%h", a, host_rvalid, host_rdata, exp_mem[a]); end
    endtask

    task automatic test_out_of_range();
        @(negedge clk); host_req = 1'b1; host_we = 1'b0; host_addr = 10'd10; #1;
        compared++; if (host_gnt !== 1'b0 || mem_read !== 1'b0) begin mismatched++; $display("FAIL oor_rd: got gnt=%b r=%b want 0 0", host_gnt, mem_read); end
        @(negedge clk); host_we = 1'b1; host_addr = 10'd11; host_wdata = 16'hFFFF; #1;
        compared++; if (host_err !== 1'b1) begin mismatched++; $display("FAIL oor_err1: got %b want 1", host_err); end
        compared++; if (host_gnt !== 1'b0 || mem_write !== 1'b0) begin mismatched++; $display("FAIL oor_wr: got gnt=%b w=%b want 0 0", host_gnt, mem_write); end
        @(negedge clk); host_req = 1'b0; host_we = 1'b0;
        compared++; if (host_err !== 1'b1 || host_rvalid !== 1'b0) begin mismatched++; $display("FAIL oor_err2: got err=%b rv=%b want 1 0", host_err, host_rvalid); end
        @(negedge clk);
        compared++; if (host_err !== 1'b0) begin mismatched++; $display("FAIL oor_pulse: got %b want 0", host_err); end
        test_host_read(9);
    endtask

    task automatic test_sort_job();
        int busy_cnt = 0, starts = 0, dones = 0;
        @(negedge clk); job_go = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 10'd0; #1;
        compared++; if (host_gnt !== 1'b1) begin mismatched++; $display("FAIL go_gnt: got %b want 1", host_gnt); end
        exp_q.push_back(exp_mem[0]);
        @(negedge clk); job_go = 1'b0; host_req = 1'b0; #1;
        compared++; if (sort_start !== 1'b1 || busy !== 1'b1 || cycles !== 16'd0)
            begin mismatched++; $display("FAIL start: got st=%b busy=%b cyc=%0d want 1 1 0", sort_start, busy, cycles); end
        compared++;
        if (host_rvalid !== 1'b1 || exp_q.size() == 0) begin
            mismatched++; $display("FAIL go_rvalid: got %b want 1", host_rvalid);
        end else begin
            last_rd = exp_q.pop_front();
            if (host_rdata !== last_rd) begin mismatched++; $display("FAIL go_rdata: got %h want %h", host_rdata, last_rd); end
        end
        if (busy) busy_cnt++;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            host_req = 1'b0; srt_read = 1'b0; srt_write = 1'b0; sort_done = (k == 50);
            if (busy) busy_cnt++;
            if (sort_start) starts++;
            if (job_done) dones++;
            if (k == 2) begin
                host_req = 1'b1; host_we = 1'b0; host_addr = 10'd1; #1;
                compared++; if (host_gnt !== 1'b0 || mem_read !== 1'b0) begin mismatched++; $display("FAIL sort_host: got gnt=%b r=%b want 0 0", host_gnt, mem_read); end
            end
            if (k == 3) begin
                compared++; if (host_err !== 1'b0) begin mismatched++; $display("FAIL sort_noerr: got %b want 0", host_err); end
                srt_write = 1'b1; srt_addr = 10'd5; srt_wdata = 16'hABCD; #1;
                exp_mem[5] = 16'hABCD;
                compared++; if (mem_write !== 1'b1 || mem_addr !== 10'd5 || mem_data_in !== 16'hABCD)
                    begin mismatched++; $display("FAIL srt_wr: got w=%b %0d/%h want 1 5/abcd", mem_write, mem_addr, mem_data_in); end
            end
            if (k == 4) begin
                srt_read = 1'b1; srt_write = 1'b1; srt_addr = 10'd6; srt_wdata = 16'h1234; #1;
                exp_mem[6] = 16'h1234;
                compared++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin mismatched++; $display("FAIL srt_both: got w=%b r=%b want 1 0", mem_write, mem_read); end
            end
            if (k == 5) begin
                compared++; if (srt_viol !== 1'b1) begin mismatched++; $display("FAIL srt_both_viol: got %b want 1", srt_viol); end
                srt_read = 1'b1; srt_addr = 10'd0; #1;
                compared++; if (mem_read !== 1'b1 || mem_addr !== 10'd0) begin mismatched++; $display("FAIL srt_rd: got r=%b a=%0d want 1 0", mem_read, mem_addr); end
            end
            if (k == 6) begin
                compared++; if (srt_rdata !== exp_mem[0]) begin mismatched++; $display("FAIL srt_rdata: got %h want %h", srt_rdata, exp_mem[0]); end
            end
            if (k == 10) begin
                compared++; if (cycles !== 16'd9) begin mismatched++; $display("FAIL cyc_mid: got %0d want 9", cycles); end
            end
        end
        @(negedge clk); sort_done = 1'b0; host_req = 1'b0;
        compared++; if (job_done !== 1'b1 || busy !== 1'b0 || cycles !== 16'd50)
            begin mismatched++; $display("FAIL finish: got done=%b busy=%b cyc=%0d want 1 0 50", job_done, busy, cycles); end
        compared++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin mismatched++; $display("FAIL fin_mem: got %b%b want 00", mem_read, mem_write); end
        compared++; if (busy_cnt != 51 || starts != 0 || dones != 0)
            begin mismatched++; $display("FAIL sort_counts: got busy=%0d st=%0d done=%0d want 51 0 0", busy_cnt, starts, dones); end
        @(negedge clk);
        compared++; if (job_done !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL post_fin: got done=%b busy=%b want 0 0", job_done, busy); end
    endtask

    task automatic test_timeout();
        int bcnt = 0, dones = 0;
        @(negedge clk); job_go = 1'b1;
        @(negedge clk); job_go = 1'b0;
        compared++; if (t_sort_start !== 1'b1 || t_job_err !== 1'b0)
            begin mismatched++; $display("FAIL to_start: got st=%b err=%b want 1 0", t_sort_start, t_job_err); end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (t_busy) bcnt++;
            if (t_job_done) dones++;
            if (k == 20) begin
                compared++; if (t_cycles !== 16'd19) begin mismatched++; $display("FAIL to_cyc19: got %0d want 19", t_cycles); end
            end
        end
        @(negedge clk);
        compared++; if (t_busy !== 1'b0 || t_job_err !== 1'b1 || t_cycles !== 16'd20)
            begin mismatched++; $display("FAIL to_abort: got busy=%b err=%b cyc=%0d want 0 1 20", t_busy, t_job_err, t_cycles); end
        compared++; if (bcnt != 20 || dones != 0 || t_job_done !== 1'b0)
            begin mismatched++; $display("FAIL to_counts: got busy=%0d done=%0d/%b want 20 0/0", bcnt, dones, t_job_done); end
        @(negedge clk); job_go = 1'b1;
        compared++; if (t_job_done !== 1'b0 || t_job_err !== 1'b1) begin mismatched++; $display("FAIL to_idle: got done=%b err=%b want 0 1", t_job_done, t_job_err); end
        @(negedge clk); job_go = 1'b0;
        compared++; if (t_job_err !== 1'b0 || t_busy !== 1'b1) begin mismatched++; $display("FAIL to_clear: got err=%b busy=%b want 0 1", t_job_err, t_busy); end
        do_reset();
    endtask

    task automatic test_reset_mid_sort();
        @(negedge clk); job_go = 1'b1;
        @(negedge clk); job_go = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 7) begin
                compared++; if (busy !== 1'b1 || cycles !== 16'd6) begin mismatched++; $display("FAIL mid_pre: got busy=%b cyc=%0d want 1 6", busy, cycles); end
                rst = 1'b1;
            end
        end
        @(negedge clk); rst = 1'b0;
        compared++; if (busy !== 1'b0 || cycles !== 16'd0 || job_done !== 1'b0 || sort_start !== 1'b0)
            begin mismatched++; $display("FAIL mid_rst: got busy=%b cyc=%0d done=%b st=%b want 0 0 0 0", busy, cycles, job_done, sort_start); end
        host_req = 1'b1; host_we = 1'b1; host_addr = 10'd2; host_wdata = 16'h0055; #1;
        exp_mem[2] = 16'h0055;
        compared++; if (host_gnt !== 1'b1 || mem_write !== 1'b1) begin mismatched++; $display("FAIL mid_host: got gnt=%b w=%b want 1 1", host_gnt, mem_write); end
        @(negedge clk); host_req = 1'b0; host_we = 1'b0;
        compared++; if (job_done !== 1'b0 || sort_start !== 1'b0) begin mismatched++; $display("FAIL mid_quiet: got done=%b st=%b want 0 0", job_done, sort_start); end
        test_host_read(2);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin mem[i] = '0; exp_mem[i] = '0; end
        test_reset();
        test_srt_viol();
        test_host_write();
        test_host_read(3);
        test_out_of_range();
        test_sort_job();
        test_host_read(5);
        test_host_read(6);
        test_host_read(0);
        test_timeout();
        test_reset_mid_sort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
